lc3_ctrl_fsm: RTL and testbench

Multi-cycle LC-3 control unit. It sequences fetch, decode, execute and writeback for the datapath: register file, ALU, PC, MAR/MDR and bus gates. It drives the register file's dr_mux, sr1_mux and load_reg selects, plus all load, gate and mux controls. Memory access uses a request/ready handshake with an optional timeout.

---
 rtl/lc3_ctrl_pkg.sv | 70 +++++++
 rtl/lc3_mem_wait.sv | 33 +++
 rtl/lc3_ctrl_fsm.sv | 169 ++++++++++++++++
 tb/tb_lc3_ctrl_fsm.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_ctrl_pkg.sv
// Shared types and encodings for the LC-3 multi-cycle control unit.
// LC3_TRAP_EN adds the TRAP states T0..T3.
package lc3_ctrl_pkg;

    typedef enum logic [4:0] {
        S_IDLE = 5'd0,
        S_F0   = 5'd1,
        S_F1   = 5'd2,
        S_F2   = 5'd3,
        S_DEC  = 5'd4,
        S_ADD  = 5'd5,
        S_AND  = 5'd6,
        S_NOT  = 5'd7,
        S_BR0  = 5'd8,
        S_JMP  = 5'd9,
        S_J0   = 5'd10,
        S_J1   = 5'd11,
        S_LEA  = 5'd12,
        S_A0   = 5'd13,
        S_M0   = 5'd14,
        S_W0   = 5'd15,
        S_S0   = 5'd16,
        S_S1   = 5'd17,
        S_HALT = 5'd18
`ifdef LC3_TRAP_EN
        ,
        S_T0   = 5'd19,
        S_T1   = 5'd20,
        S_T2   = 5'd21,
        S_T3   = 5'd22
`endif
    } state_t;

    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_LD   = 4'b0010;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_JSR  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_LDR  = 4'b0110;
    localparam logic [3:0] OP_STR  = 4'b0111;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_LEA  = 4'b1110;
    localparam logic [3:0] OP_TRAP = 4'b1111;

    localparam logic [1:0] PC_PLUS1 = 2'd0;
    localparam logic [1:0] PC_BUS   = 2'd1;
    localparam logic [1:0] PC_ADDER = 2'd2;

    localparam logic [1:0] A2_ZERO  = 2'd0;
    localparam logic [1:0] A2_OFF6  = 2'd1;
    localparam logic [1:0] A2_OFF9  = 2'd2;
    localparam logic [1:0] A2_OFF11 = 2'd3;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_AND   = 2'd1;
    localparam logic [1:0] ALU_NOT   = 2'd2;
    localparam logic [1:0] ALU_PASSA = 2'd3;

    // States that hold a memory request open until mem_ready.
    function automatic logic is_wait(input state_t s);
        return (s == S_F1) || (s == S_M0) || (s == S_S1)
`ifdef LC3_TRAP_EN
               || (s == S_T2)
`endif
               ;
    endfunction

endpackage

// File: rtl/lc3_mem_wait.sv
// Memory wait counter with optional timeout for the LC-3 control unit.
module lc3_mem_wait #(
    parameter int MEM_TIMEOUT = 0,
    parameter int CNT_W       = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic mem_ready,
    output logic done,
    output logic timeout
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MEM_TIMEOUT - 1);

    logic [CNT_W-1:0] cnt;

    // start is high for the whole stay in a wait state; low clears the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!start) begin
            cnt <= '0;
        end else if (!mem_ready && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign done = start & mem_ready;
    // Fires on the edge where the count would reach MEM_TIMEOUT.
    assign timeout = (MEM_TIMEOUT != 0) && start && !mem_ready && (cnt == LIMIT);

endmodule

// File: rtl/lc3_ctrl_fsm.sv
// LC-3 multi-cycle control FSM: fetch, decode, execute, writeback.
// Define LC3_TRAP_EN to execute TRAP (1111); otherwise it halts as illegal.
module lc3_ctrl_fsm
    import lc3_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 0,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] ir,
    input  logic        n_flag,
    input  logic        z_flag,
    input  logic        p_flag,
    input  logic        mem_ready,
    output logic        ld_mar,
    output logic        ld_mdr,
    output logic        ld_ir,
    output logic        ld_pc,
    output logic        ld_cc,
    output logic        ld_reg,
    output logic        gate_pc,
    output logic        gate_mdr,
    output logic        gate_alu,
    output logic        gate_marmux,
    output logic        dr_mux,
    output logic        sr1_mux,
    output logic [1:0]  pc_mux,
    output logic        addr1_mux,
    output logic [1:0]  addr2_mux,
    output logic        marmux,
    output logic [1:0]  alu_op,
    output logic        mem_en,
    output logic        mem_we,
    output logic        illegal,
    output logic [4:0]  state_o
);

    state_t state, state_next;
    logic   wait_active, mem_done, mem_timeout, br_taken, unused_ir;

    assign wait_active = is_wait(state);
    assign br_taken    = (ir[11] & n_flag) | (ir[10] & z_flag) | (ir[9] & p_flag);
    assign unused_ir   = ^ir[8:0];
    assign state_o     = state;

    lc3_mem_wait #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) u_mem_wait (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (wait_active),
        .mem_ready (mem_ready),
        .done      (mem_done),
        .timeout   (mem_timeout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: state_next = S_F0;
            S_F0:   state_next = S_F1;
            S_F1: begin
                if (mem_done)         state_next = S_F2;
                else if (mem_timeout) state_next = S_HALT;
            end
            S_F2:   state_next = S_DEC;
            S_DEC: begin
                case (ir[15:12])
                    OP_ADD:  state_next = S_ADD;
                    OP_AND:  state_next = S_AND;
                    OP_NOT:  state_next = S_NOT;
                    OP_BR:   state_next = br_taken ? S_BR0 : S_F0;
                    OP_JMP:  state_next = S_JMP;
                    OP_JSR:  state_next = S_J0;
                    OP_LEA:  state_next = S_LEA;
                    OP_LD, OP_LDR, OP_ST, OP_STR: state_next = S_A0;
`ifdef LC3_TRAP_EN
                    OP_TRAP: state_next = S_T0;
`else
                    OP_TRAP: state_next = S_HALT;
`endif
                    // Indirect loads/stores and reserved opcodes are not executed.
                    default: state_next = S_HALT;
                endcase
            end
            S_ADD, S_AND, S_NOT, S_BR0, S_JMP, S_J1, S_LEA, S_W0: state_next = S_F0;
            S_J0:   state_next = S_J1;
            S_A0:   state_next = ir[12] ? S_S0 : S_M0;
            S_M0: begin
                if (mem_done)         state_next = S_W0;
                else if (mem_timeout) state_next = S_HALT;
            end
            S_S0:   state_next = S_S1;
            S_S1: begin
                if (mem_done)         state_next = S_F0;
                else if (mem_timeout) state_next = S_HALT;
            end
            S_HALT: state_next = S_HALT;
`ifdef LC3_TRAP_EN
            S_T0:   state_next = S_T1;
            S_T1:   state_next = S_T2;
            S_T2: begin
                if (mem_done)         state_next = S_T3;
                else if (mem_timeout) state_next = S_HALT;
            end
            S_T3:   state_next = S_F0;
`endif
            default: state_next = S_HALT;
        endcase
    end

    // IR is stable from DEC onward, so the mode bits used in A0/J1 are constant per state.
    always_comb begin
        ld_mar = 1'b0; ld_mdr = 1'b0; ld_ir = 1'b0; ld_pc = 1'b0;
        ld_cc = 1'b0; ld_reg = 1'b0;
        gate_pc = 1'b0; gate_mdr = 1'b0; gate_alu = 1'b0; gate_marmux = 1'b0;
        dr_mux = 1'b0; sr1_mux = 1'b0; pc_mux = PC_PLUS1; addr1_mux = 1'b0;
        addr2_mux = A2_ZERO; marmux = 1'b0; alu_op = ALU_ADD;
        mem_en = 1'b0; mem_we = 1'b0; illegal = 1'b0;
        case (state)
            S_F0:  begin gate_pc = 1'b1; ld_mar = 1'b1; pc_mux = PC_PLUS1; ld_pc = 1'b1; end
            S_F1:  begin mem_en = 1'b1; ld_mdr = 1'b1; end
            S_F2:  begin gate_mdr = 1'b1; ld_ir = 1'b1; end
            S_ADD: begin sr1_mux = 1'b1; gate_alu = 1'b1; ld_reg = 1'b1; ld_cc = 1'b1; alu_op = ALU_ADD; end
            S_AND: begin sr1_mux = 1'b1; gate_alu = 1'b1; ld_reg = 1'b1; ld_cc = 1'b1; alu_op = ALU_AND; end
            S_NOT: begin sr1_mux = 1'b1; gate_alu = 1'b1; ld_reg = 1'b1; ld_cc = 1'b1; alu_op = ALU_NOT; end
            S_BR0: begin addr2_mux = A2_OFF9; pc_mux = PC_ADDER; ld_pc = 1'b1; end
            S_JMP: begin sr1_mux = 1'b1; alu_op = ALU_PASSA; gate_alu = 1'b1; pc_mux = PC_BUS; ld_pc = 1'b1; end
            S_J0:  begin gate_pc = 1'b1; dr_mux = 1'b1; ld_reg = 1'b1; end
            S_J1: begin
                ld_pc = 1'b1;
                if (ir[11]) begin
                    addr2_mux = A2_OFF11; pc_mux = PC_ADDER;
                end else begin
                    sr1_mux = 1'b1; alu_op = ALU_PASSA; gate_alu = 1'b1; pc_mux = PC_BUS;
                end
            end
            S_LEA: begin addr2_mux = A2_OFF9; marmux = 1'b1; gate_marmux = 1'b1; ld_reg = 1'b1; ld_cc = 1'b1; end
            S_A0: begin
                ld_mar = 1'b1; gate_marmux = 1'b1; marmux = 1'b1;
                if (ir[14]) begin
                    addr1_mux = 1'b1; sr1_mux = 1'b1; addr2_mux = A2_OFF6;
                end else begin
                    addr2_mux = A2_OFF9;
                end
            end
            S_M0:  begin mem_en = 1'b1; ld_mdr = 1'b1; end
            S_W0:  begin gate_mdr = 1'b1; ld_reg = 1'b1; ld_cc = 1'b1; end
            S_S0:  begin alu_op = ALU_PASSA; gate_alu = 1'b1; ld_mdr = 1'b1; end
            S_S1:  begin mem_en = 1'b1; mem_we = 1'b1; end
            S_HALT: illegal = 1'b1;
`ifdef LC3_TRAP_EN
            S_T0:  begin gate_pc = 1'b1; dr_mux = 1'b1; ld_reg = 1'b1; end
            S_T1:  begin gate_marmux = 1'b1; ld_mar = 1'b1; end
            S_T2:  begin mem_en = 1'b1; ld_mdr = 1'b1; end
            S_T3:  begin gate_mdr = 1'b1; pc_mux = PC_BUS; ld_pc = 1'b1; end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lc3_ctrl_fsm.sv
// Directed bench for lc3_ctrl_fsm: vector table plus multi-cycle sequences.
module tb_lc3_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] ir = '0;
    logic        n_flag = 1'b0, z_flag = 1'b0, p_flag = 1'b0;
    logic        mem_ready = 1'b1;
    logic        ld_mar, ld_mdr, ld_ir, ld_pc, ld_cc, ld_reg;
    logic        gate_pc, gate_mdr, gate_alu, gate_marmux;
    logic        dr_mux, sr1_mux, addr1_mux, marmux, mem_en, mem_we, illegal;
    logic [1:0]  pc_mux, addr2_mux, alu_op;
    logic [4:0]  state_o;

    int n_checks = 0;
    int n_fail   = 0;

    lc3_ctrl_fsm #(.MEM_TIMEOUT(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .ir(ir),
        .n_flag(n_flag), .z_flag(z_flag), .p_flag(p_flag), .mem_ready(mem_ready),
        .ld_mar(ld_mar), .ld_mdr(ld_mdr), .ld_ir(ld_ir), .ld_pc(ld_pc),
        .ld_cc(ld_cc), .ld_reg(ld_reg),
        .gate_pc(gate_pc), .gate_mdr(gate_mdr), .gate_alu(gate_alu), .gate_marmux(gate_marmux),
        .dr_mux(dr_mux), .sr1_mux(sr1_mux), .pc_mux(pc_mux), .addr1_mux(addr1_mux),
        .addr2_mux(addr2_mux), .marmux(marmux), .alu_op(alu_op),
        .mem_en(mem_en), .mem_we(mem_we), .illegal(illegal), .state_o(state_o)
    );

    always #5 clk = ~clk;

    localparam logic [4:0] ST_IDLE = 5'd0,  ST_F0 = 5'd1,  ST_F1 = 5'd2,  ST_F2 = 5'd3;
    localparam logic [4:0] ST_DEC  = 5'd4,  ST_ADD = 5'd5, ST_AND = 5'd6, ST_NOT = 5'd7;
    localparam logic [4:0] ST_BR0  = 5'd8,  ST_JMP = 5'd9, ST_J0 = 5'd10, ST_J1 = 5'd11;
    localparam logic [4:0] ST_LEA  = 5'd12, ST_A0 = 5'd13, ST_M0 = 5'd14, ST_W0 = 5'd15;
    localparam logic [4:0] ST_S0   = 5'd16, ST_S1 = 5'd17, ST_HALT = 5'd18;
    localparam logic [4:0] ST_T0   = 5'd19, ST_T1 = 5'd20, ST_T2 = 5'd21, ST_T3 = 5'd22;

    localparam logic [22:0] LD_MAR = 23'd1 << 22, LD_MDR = 23'd1 << 21, LD_IR = 23'd1 << 20;
    localparam logic [22:0] LD_PC = 23'd1 << 19, LD_CC = 23'd1 << 18, LD_REG = 23'd1 << 17;
    localparam logic [22:0] GATE_PC = 23'd1 << 16, GATE_MDR = 23'd1 << 15;
    localparam logic [22:0] GATE_ALU = 23'd1 << 14, GATE_MARMUX = 23'd1 << 13;
    localparam logic [22:0] DR_MUX = 23'd1 << 12, SR1_MUX = 23'd1 << 11, ADDR1 = 23'd1 << 8;
    localparam logic [22:0] MARMUX = 23'd1 << 5, MEM_EN = 23'd1 << 2, MEM_WE = 23'd1 << 1;
    localparam logic [22:0] ILLEGAL = 23'd1;
    localparam logic [22:0] NONE = 23'd0;

    function automatic logic [22:0] pcm(input logic [1:0] v); return {12'd0, v, 9'd0}; endfunction
    function automatic logic [22:0] a2m(input logic [1:0] v); return {15'd0, v, 6'd0}; endfunction
    function automatic logic [22:0] alu(input logic [1:0] v); return {18'd0, v, 3'd0}; endfunction

    function automatic logic [22:0] outs();
        return {ld_mar, ld_mdr, ld_ir, ld_pc, ld_cc, ld_reg, gate_pc, gate_mdr, gate_alu,
                gate_marmux, dr_mux, sr1_mux, pc_mux, addr1_mux, addr2_mux, marmux, alu_op,
                mem_en, mem_we, illegal};
    endfunction

    logic [22:0] f0_out, f1_out, f2_out, alu_exe;

    typedef struct {
        string       name;
        logic [15:0] ir;
        logic [2:0]  nzp;
        logic [4:0]  st;
        logic [22:0] out;
        logic [4:0]  nxt;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [4:0] st, input logic [22:0] exp);
        n_checks++;
        if (state_o !== st) begin
            n_fail++;
            $display("FAIL %s state: got %0d expected %0d", name, state_o, st);
        end
        n_checks++;
        if (outs() !== exp) begin
            n_fail++;
            $display("FAIL %s outputs: got %h expected %h", name, outs(), exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset mid-cycle; leaves the FSM in F0 one cycle after release.
    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        chk("reset_async", ST_IDLE, NONE);
        tick();
        rst_n = 1'b1;
        chk("reset_release", ST_IDLE, NONE);
        tick();
    endtask

    task automatic fetch(input logic [15:0] i);
        ir = i;
        chk("fetch_f0", ST_F0, f0_out);  tick();
        chk("fetch_f1", ST_F1, f1_out);  tick();
        chk("fetch_f2", ST_F2, f2_out);  tick();
        chk("fetch_dec", ST_DEC, NONE);  tick();
    endtask

    // Bus and MDR exclusivity, checked every cycle away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            n_checks++;
            if ((ld_mdr && gate_mdr) || ($countones({gate_pc, gate_mdr, gate_alu, gate_marmux}) > 1)) begin
                n_fail++;
                $display("FAIL bus_excl: gates=%b ld_mdr=%b", {gate_pc, gate_mdr, gate_alu, gate_marmux}, ld_mdr);
            end
        end
    end

    initial begin
        f0_out  = GATE_PC | LD_MAR | LD_PC | pcm(2'd0);
        f1_out  = MEM_EN | LD_MDR;
        f2_out  = GATE_MDR | LD_IR;
        alu_exe = SR1_MUX | GATE_ALU | LD_REG | LD_CC;

        vecs[0]  = '{"add",   16'h1242, 3'b000, ST_ADD,  alu_exe | alu(2'd0), ST_F0};
        vecs[1]  = '{"and",   16'h5242, 3'b000, ST_AND,  alu_exe | alu(2'd1), ST_F0};
        vecs[2]  = '{"not",   16'h927F, 3'b000, ST_NOT,  alu_exe | alu(2'd2), ST_F0};
        vecs[3]  = '{"jmp",   16'hC1C0, 3'b000, ST_JMP,  SR1_MUX | alu(2'd3) | GATE_ALU | pcm(2'd1) | LD_PC, ST_F0};
        vecs[4]  = '{"lea",   16'hE405, 3'b000, ST_LEA,  a2m(2'd2) | MARMUX | GATE_MARMUX | LD_REG | LD_CC, ST_F0};
        vecs[5]  = '{"br_z",  16'h0405, 3'b010, ST_BR0,  pcm(2'd2) | a2m(2'd2) | LD_PC, ST_F0};
        vecs[6]  = '{"br_nt", 16'h0805, 3'b010, ST_F0,   GATE_PC | LD_MAR | LD_PC, ST_F1};
        vecs[7]  = '{"br_n",  16'h0E05, 3'b100, ST_BR0,  pcm(2'd2) | a2m(2'd2) | LD_PC, ST_F0};
        vecs[8]  = '{"br_p",  16'h0200, 3'b001, ST_BR0,  pcm(2'd2) | a2m(2'd2) | LD_PC, ST_F0};
        vecs[9]  = '{"br_off",16'h0E05, 3'b000, ST_F0,   GATE_PC | LD_MAR | LD_PC, ST_F1};
        vecs[10] = '{"ill_8", 16'h8000, 3'b000, ST_HALT, ILLEGAL, ST_HALT};
        vecs[11] = '{"ill_d", 16'hD000, 3'b000, ST_HALT, ILLEGAL, ST_HALT};
`ifdef LC3_TRAP_EN
        vecs[12] = '{"trap",  16'hF025, 3'b000, ST_T0,   GATE_PC | DR_MUX | LD_REG, ST_T1};
`else
        vecs[12] = '{"trap",  16'hF025, 3'b000, ST_HALT, ILLEGAL, ST_HALT};
`endif

        #2;
        for (int i = 0; i < 13; i++) begin
            do_reset();
            {n_flag, z_flag, p_flag} = vecs[i].nzp;
            fetch(vecs[i].ir);
            chk(vecs[i].name, vecs[i].st, vecs[i].out);
            tick();
            n_checks++;
            if (state_o !== vecs[i].nxt) begin
                n_fail++;
                $display("FAIL %s next: got %0d expected %0d", vecs[i].name, state_o, vecs[i].nxt);
            end
        end
        {n_flag, z_flag, p_flag} = 3'b000;

        // LD with mem_ready held low for the first three M0 cycles.
        do_reset();
        fetch(16'h2405);
        chk("ld_a0", ST_A0, LD_MAR | GATE_MARMUX | MARMUX | a2m(2'd2));
        mem_ready = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) begin
            if (k == 3) mem_ready = 1'b1;
            chk("ld_m0_hold", ST_M0, MEM_EN | LD_MDR);
            tick();
        end
        chk("ld_w0", ST_W0, GATE_MDR | LD_REG | LD_CC);
        tick();
        chk("ld_done", ST_F0, f0_out);

        // STR through A0, S0, S1.
        do_reset();
        fetch(16'h7285);
        chk("str_a0", ST_A0, LD_MAR | GATE_MARMUX | MARMUX | ADDR1 | SR1_MUX | a2m(2'd1));
        tick();
        chk("str_s0", ST_S0, GATE_ALU | LD_MDR | alu(2'd3));
        tick();
        chk("str_s1", ST_S1, MEM_EN | MEM_WE);
        tick();
        chk("str_done", ST_F0, f0_out);

        // JSR with PC offset, then JSRR through a base register.
        do_reset();
        fetch(16'h4805);
        chk("jsr_j0", ST_J0, GATE_PC | DR_MUX | LD_REG);
        tick();
        chk("jsr_j1", ST_J1, pcm(2'd2) | a2m(2'd3) | LD_PC);
        tick();
        chk("jsr_done", ST_F0, f0_out);
        do_reset();
        fetch(16'h4080);
        chk("jsrr_j0", ST_J0, GATE_PC | DR_MUX | LD_REG);
        tick();
        chk("jsrr_j1", ST_J1, SR1_MUX | alu(2'd3) | GATE_ALU | pcm(2'd1) | LD_PC);
        tick();
        chk("jsrr_done", ST_F0, f0_out);

        // Reset in the middle of an LDR memory wait, then a clean ADD.
        do_reset();
        fetch(16'h6285);
        chk("ldr_a0", ST_A0, LD_MAR | GATE_MARMUX | MARMUX | ADDR1 | SR1_MUX | a2m(2'd1));
        mem_ready = 1'b0;
        tick();
        chk("ldr_m0a", ST_M0, MEM_EN | LD_MDR);
        tick();
        chk("ldr_m0b", ST_M0, MEM_EN | LD_MDR);
        do_reset();
        mem_ready = 1'b1;
        fetch(16'h1242);
        chk("add_after_rst", ST_ADD, alu_exe);
        tick();
        chk("add_f0_again", ST_F0, f0_out);

        // Fetch timeout: mem_ready stuck low in F1.
        do_reset();
        mem_ready = 1'b0;
        chk("to_f0", ST_F0, f0_out);
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("to_f1_wait", ST_F1, f1_out);
            tick();
        end
        chk("to_halt", ST_HALT, ILLEGAL);
        mem_ready = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        chk("to_halt_sticky", ST_HALT, ILLEGAL);

`ifdef LC3_TRAP_EN
        do_reset();
        fetch(16'hF025);
        chk("trap_t0", ST_T0, GATE_PC | DR_MUX | LD_REG);
        tick();
        chk("trap_t1", ST_T1, GATE_MARMUX | LD_MAR);
        tick();
        chk("trap_t2", ST_T2, MEM_EN | LD_MDR);
        tick();
        chk("trap_t3", ST_T3, GATE_MDR | pcm(2'd1) | LD_PC);
        tick();
        chk("trap_done", ST_F0, f0_out);
`endif

        do_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
